// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I encodings, LSU state type and store-lane helpers for the memory stage.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Halfword lanes follow addr[1] only; a word store always enables every lane.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   store_be = 4'b0001 << off;
      F3_SH:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      F3_SB:   store_wdata = {4{rs2[7:0]}};
      F3_SH:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/acknowledge data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load data formatter: picks the addressed byte/halfword from a read word and extends it.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    byte_s  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_s  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sx = 32'(byte_s);
    half_sx = 32'(half_s);
    case (funct3_i)
      F3_LB:   data_o = byte_sx;
      F3_LH:   data_o = half_sx;
      F3_LBU:  data_o = {24'd0, byte_s};
      F3_LHU:  data_o = {16'd0, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: req/ack data access, upstream stall, MEM/WB register.
// Build option MISALIGN_TRAP_EN adds misalignW and suppresses misaligned accesses.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [31:0]           PCPlus4M,
  output logic                  StallM,
  mem_stage_lsu_if.master       mem,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [ADDR_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [4:0]            RdW,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalignW,
`endif
  output logic [31:0]           PCPlus4W
);

  lsu_state_t            state_q;
  logic                  req_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  regwrite_q;
  logic [1:0]            resultsrc_q;
  logic [ADDR_WIDTH-1:0] aluresult_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic [4:0]            rd_q;
  logic [31:0]           pcplus4_q;
  logic                  misalign_q;

  logic                  memop, misalign, access, busy_ack;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata_fmt_d;

  assign memop = MemWriteM | (ResultSrcM == RES_LOAD);

`ifdef MISALIGN_TRAP_EN
  assign misalign = memop & is_misaligned(funct3M, ALUResultM[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign access   = memop & ~misalign;
  assign busy_ack = (state_q == BUSY) & mem.mem_ack;
  // Gated by rst so the stall drops the instant reset is asserted.
  assign StallM   = ~rst & access & ~busy_ack;

  assign be_d    = MemWriteM ? store_be(funct3M, ALUResultM[1:0]) : 4'b1111;
  assign wdata_d = store_wdata(funct3M, WriteDataM);

  mem_stage_lsu_load_align u_load_align (
    .rdata_i   (mem.mem_rdata),
    .addr_lo_i (ALUResultM[1:0]),
    .funct3_i  (funct3M),
    .data_o    (rdata_fmt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      aluresult_q <= '0;
      readdata_q  <= '0;
      rd_q        <= '0;
      pcplus4_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q    <= BUSY;
            req_q      <= 1'b1;
            we_q       <= MemWriteM;
            addr_q     <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            regwrite_q <= 1'b0;
          end else begin
            // Plain ALU ops and trapped misaligned accesses pass straight to WB.
            regwrite_q  <= RegWriteM & ~misalign;
            resultsrc_q <= ResultSrcM;
            aluresult_q <= ALUResultM;
            readdata_q  <= '0;
            rd_q        <= RdM;
            pcplus4_q   <= PCPlus4M;
            misalign_q  <= misalign;
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            regwrite_q  <= RegWriteM;
            resultsrc_q <= ResultSrcM;
            aluresult_q <= ALUResultM;
            readdata_q  <= we_q ? '0 : rdata_fmt_d;
            rd_q        <= RdM;
            pcplus4_q   <= PCPlus4M;
          end else begin
            regwrite_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign ALUResultW = aluresult_q;
  assign ReadDataW  = readdata_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pcplus4_q;
`ifdef MISALIGN_TRAP_EN
  assign misalignW  = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (define MISALIGN_TRAP_EN to cover the trap build).
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [4:0]  RdM = 5'd0;
  logic [31:0] PCPlus4M = 32'h0;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
`ifdef MISALIGN_TRAP_EN
  logic        misalignW;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .StallM     (StallM),
    .mem        (bus),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
`ifdef MISALIGN_TRAP_EN
    .misalignW  (misalignW),
`endif
    .PCPlus4W   (PCPlus4W)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
  endtask

  task automatic clear_m;
    drive_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_reset;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd9, 32'h4);
    tick; tick;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", StallM); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 69'd0) begin errors++; $display("FAIL reset_bus got %h exp 0", {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}); end
    checks++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W} !== 104'd0) begin errors++; $display("FAIL reset_wb got %h exp 0", {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W}); end
    clear_m;
    rst = 1'b0;
  endtask

  task automatic test_alu;
    drive_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h2004);
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", StallM); end
    tick;
    checks++; if (RdW !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", RdW); end
    checks++; if (ALUResultW !== 32'h1234) begin errors++; $display("FAIL alu_result got %h exp 00001234", ALUResultW); end
    checks++; if ({RegWriteW, ResultSrcW, ReadDataW, PCPlus4W} !== {1'b1, 2'b00, 32'h0, 32'h2004}) begin errors++; $display("FAIL alu_wb got %b %b %h %h exp 1 00 0 2004", RegWriteW, ResultSrcW, ReadDataW, PCPlus4W); end
    checks++; if (StallM !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL alu_nostall got %b/%b exp 0/0", StallM, bus.mem_req); end
    clear_m;
  endtask

  task automatic test_lw_wait;
    int stalls;
    int bubbles;
    stalls = 0; bubbles = 0;
    drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 32'h3008);
    #1;
    if (StallM === 1'b1) stalls++;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL lw_req_early got %b exp 0", bus.mem_req); end
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin errors++; $display("FAIL lw_bus_c%0d got %b %b %h %b exp 1 0 00000100 1111", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be); end
      if (c >= 1 && RegWriteW === 1'b0) bubbles++;
      if (c == 3) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
      end
      if (StallM === 1'b1) stalls++;
    end
    checks++; if (stalls != 4) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 4", stalls); end
    checks++; if (bubbles != 3) begin errors++; $display("FAIL lw_bubbles got %0d exp 3", bubbles); end
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", ReadDataW); end
    checks++; if ({RegWriteW, ResultSrcW, RdW, bus.mem_req} !== {1'b1, 2'b01, 5'd7, 1'b0}) begin errors++; $display("FAIL lw_wb got %b %b %0d req %b exp 1 01 7 req 0", RegWriteW, ResultSrcW, RdW, bus.mem_req); end
    clear_m;
  endtask

  task automatic test_byte_loads;
    logic [2:0]  f3s [2]  = '{3'b000, 3'b100};
    logic [31:0] exps [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int k = 0; k < 2; k++) begin
      drive_m(1'b1, 2'b01, 1'b0, f3s[k], 32'h103, 32'h0, 5'd11, 32'h500);
      tick;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'hF) begin errors++; $display("FAIL byte_req_%0d got %b %b exp 1 1111", k, bus.mem_req, bus.mem_be); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80FFFF00;
      #1;
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL byte_ackstall_%0d got %b exp 0", k, StallM); end
      tick;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      checks++; if (ReadDataW !== exps[k]) begin errors++; $display("FAIL byte_data_%0d got %h exp %h", k, ReadDataW, exps[k]); end
    end
    // LH at 0x102 selects the upper half and sign-extends; LHU at 0x100 zero-extends the lower half.
    drive_m(1'b1, 2'b01, 1'b0, 3'b001, 32'h102, 32'h0, 5'd12, 32'h504);
    tick; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_F00F;
    tick; bus.mem_ack = 1'b0;
    checks++; if (ReadDataW !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", ReadDataW); end
    drive_m(1'b1, 2'b01, 1'b0, 3'b101, 32'h100, 32'h0, 5'd12, 32'h508);
    tick; bus.mem_ack = 1'b1;
    tick; bus.mem_ack = 1'b0;
    checks++; if (ReadDataW !== 32'h0000F00F) begin errors++; $display("FAIL lhu_data got %h exp 0000f00f", ReadDataW); end
    clear_m;
  endtask

  task automatic test_stores;
    logic [2:0]  f3s  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] addrs[3] = '{32'h0A, 32'h05, 32'h20};
    logic [31:0] rs2s [3] = '{32'h0000ABCD, 32'h12345677, 32'hCAFEF00D};
    logic [31:0] eaddr[3] = '{32'h08, 32'h04, 32'h20};
    logic [3:0]  ebe  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd  [3] = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
    for (int k = 0; k < 3; k++) begin
      drive_m(1'b0, 2'b00, 1'b1, f3s[k], addrs[k], rs2s[k], 5'd0, 32'h600);
      tick;
      checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, eaddr[k]}) begin errors++; $display("FAIL st_addr_%0d got %b %b %h exp 1 1 %h", k, bus.mem_req, bus.mem_we, bus.mem_addr, eaddr[k]); end
      checks++; if (bus.mem_be !== ebe[k] || bus.mem_wdata !== ewd[k]) begin errors++; $display("FAIL st_lanes_%0d got %b %h exp %b %h", k, bus.mem_be, bus.mem_wdata, ebe[k], ewd[k]); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
      tick;
      bus.mem_ack = 1'b0;
      checks++; if ({bus.mem_req, RegWriteW, ReadDataW} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL st_done_%0d got %b %b %h exp 0 0 0", k, bus.mem_req, RegWriteW, ReadDataW); end
    end
`ifndef MISALIGN_TRAP_EN
    // Without the trap, a word store ignores the low address bits.
    drive_m(1'b0, 2'b00, 1'b1, 3'b010, 32'h23, 32'h01020304, 5'd0, 32'h604);
    tick;
    checks++; if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h20, 4'hF}) begin errors++; $display("FAIL sw_unaligned got %b %h %b exp 1 00000020 1111", bus.mem_req, bus.mem_addr, bus.mem_be); end
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
`endif
    clear_m;
  endtask

  task automatic test_reset_busy;
    drive_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 32'h40);
    tick;
    drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 32'h44);
    tick;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rb_req_before got %b exp 1", bus.mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rb_drop got req %b stall %b exp 0 0", bus.mem_req, StallM); end
    checks++; if ({RegWriteW, ALUResultW, RdW, PCPlus4W} !== 70'd0) begin errors++; $display("FAIL rb_wb got %b %h %0d %h exp 0", RegWriteW, ALUResultW, RdW, PCPlus4W); end
    clear_m;
    tick;
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    tick;
    bus.mem_ack = 1'b0;
    checks++; if ({bus.mem_req, RegWriteW, ReadDataW} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL rb_late_ack got %b %b %h exp 0 0 0", bus.mem_req, RegWriteW, ReadDataW); end
  endtask

  task automatic test_ack_idle;
    drive_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h77, 32'h0, 5'd9, 32'h80);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL idle_ack_stall got %b exp 0", StallM); end
    tick;
    bus.mem_ack = 1'b0;
    checks++; if ({RegWriteW, ALUResultW, ReadDataW, RdW, bus.mem_req} !== {1'b1, 32'h77, 32'h0, 5'd9, 1'b0}) begin errors++; $display("FAIL idle_ack_wb got %b %h %h %0d %b exp 1 77 0 9 0", RegWriteW, ALUResultW, ReadDataW, RdW, bus.mem_req); end
    clear_m;
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign;
    drive_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 32'h90);
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", StallM); end
    tick;
    checks++; if ({bus.mem_req, misalignW, RegWriteW, ALUResultW} !== {1'b0, 1'b1, 1'b0, 32'h102}) begin errors++; $display("FAIL mis_wb got req %b mis %b rw %b %h exp 0 1 0 102", bus.mem_req, misalignW, RegWriteW, ALUResultW); end
    clear_m;
    tick;
    checks++; if (misalignW !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b exp 0", misalignW); end
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_lw_wait;
    test_byte_loads;
    test_stores;
    test_reset_busy;
    test_ack_idle;
`ifdef MISALIGN_TRAP_EN
    test_misalign;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
